key_event: RTL and testbench

KEY_EVENT -- requirements
Module: key_event

---
 rtl/key_event_if.sv | 31 +++
 rtl/key_event.sv | 125 ++++++++++++
 tb/tb_key_event.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/key_event_if.sv
// key_event_if: key level in, press/click/long/repeat events out.
// master drives KEYON and observes events; slave is key_event itself.
interface key_event_if;
   logic       KEYON;
   logic       press_p;
   logic       click_p;
   logic       long_p;
   logic       repeat_p;
   logic       held;
   logic [7:0] repeat_count;

   modport master (
      output KEYON,
      input  press_p,
      input  click_p,
      input  long_p,
      input  repeat_p,
      input  held,
      input  repeat_count
   );

   modport slave (
      input  KEYON,
      output press_p,
      output click_p,
      output long_p,
      output repeat_p,
      output held,
      output repeat_count
   );
endinterface

// File: rtl/key_event.sv
// key_event: IDLE/PRESS/HOLD key classifier with registered event pulses.
// Define KEY_EVENT_AUTOREPEAT_EN to compile in auto-repeat while held.
module key_event #(
   parameter logic [23:0] LONG_CYCLES   = 24'd12_000_000,
   parameter logic [23:0] REPEAT_CYCLES = 24'd3_000_000
) (
   input  logic       clock,
   input  logic       reset_n,
   key_event_if.slave ev
);

   typedef enum logic [1:0] {
      IDLE,
      PRESS,
      HOLD
   } state_t;

   localparam logic [23:0] LONG_LAST = LONG_CYCLES - 24'd1;

   state_t      state;
   logic [23:0] hold_cnt;
   logic        press_q;
   logic        click_q;
   logic        long_q;
   logic        held_q;

   // Both thresholds compare against N-1, so N must be at least 2.
   if (LONG_CYCLES < 24'd2 || REPEAT_CYCLES < 24'd2) begin : g_bad_cfg
      $error("key_event: LONG_CYCLES and REPEAT_CYCLES must be >= 2");
   end

`ifdef KEY_EVENT_AUTOREPEAT_EN
   localparam logic [23:0] REP_LAST = REPEAT_CYCLES - 24'd1;

   logic [23:0] rep_cnt;
   logic        repeat_q;
   logic [7:0]  rcount_q;
`endif

   // Key FSM; every output is a flop so KEYON never reaches a port directly.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         hold_cnt <= '0;
         press_q  <= 1'b0;
         click_q  <= 1'b0;
         long_q   <= 1'b0;
         held_q   <= 1'b0;
`ifdef KEY_EVENT_AUTOREPEAT_EN
         rep_cnt  <= '0;
         repeat_q <= 1'b0;
         rcount_q <= '0;
`endif
      end else begin
         press_q  <= 1'b0;
         click_q  <= 1'b0;
         long_q   <= 1'b0;
`ifdef KEY_EVENT_AUTOREPEAT_EN
         repeat_q <= 1'b0;
`endif
         unique case (state)
            IDLE: begin
               if (ev.KEYON) begin
                  state    <= PRESS;
                  hold_cnt <= '0;
                  press_q  <= 1'b1;
`ifdef KEY_EVENT_AUTOREPEAT_EN
                  rcount_q <= '0;
`endif
               end
            end
            PRESS: begin
               // Release is tested first so it beats the threshold.
               if (!ev.KEYON) begin
                  state   <= IDLE;
                  click_q <= 1'b1;
               end else if (hold_cnt == LONG_LAST) begin
                  state  <= HOLD;
                  long_q <= 1'b1;
                  held_q <= 1'b1;
`ifdef KEY_EVENT_AUTOREPEAT_EN
                  rep_cnt <= '0;
`endif
               end else begin
                  hold_cnt <= hold_cnt + 24'd1;
               end
            end
            HOLD: begin
               if (!ev.KEYON) begin
                  state  <= IDLE;
                  held_q <= 1'b0;
               end
`ifdef KEY_EVENT_AUTOREPEAT_EN
               else if (rep_cnt == REP_LAST) begin
                  rep_cnt  <= '0;
                  repeat_q <= 1'b1;
                  if (rcount_q != 8'hFF) begin
                     rcount_q <= rcount_q + 8'd1;
                  end
               end else begin
                  rep_cnt <= rep_cnt + 24'd1;
               end
`endif
            end
            default: begin
               state  <= IDLE;
               held_q <= 1'b0;
            end
         endcase
      end
   end

   assign ev.press_p      = press_q;
   assign ev.click_p      = click_q;
   assign ev.long_p       = long_q;
   assign ev.held         = held_q;
`ifdef KEY_EVENT_AUTOREPEAT_EN
   assign ev.repeat_p     = repeat_q;
   assign ev.repeat_count = rcount_q;
`else
   assign ev.repeat_p     = 1'b0;
   assign ev.repeat_count = 8'd0;
`endif

endmodule

// File: tb/tb_key_event.sv
// tb_key_event: directed key patterns, per-cycle event masks vs hand values.
// Expectations follow KEY_EVENT_AUTOREPEAT_EN when it is defined.
module tb_key_event;

   logic clock;
   logic reset_n;

   key_event_if kif ();

   key_event #(
      .LONG_CYCLES  (24'd8),
      .REPEAT_CYCLES(24'd4)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .ev     (kif.slave)
   );

`ifdef KEY_EVENT_AUTOREPEAT_EN
   localparam logic [31:0] B_REP_MASK = 32'h0001_1000;
   localparam logic [31:0] B_RCOUNT   = 32'd2;
   localparam logic [31:0] E_REP_N    = 32'd272;
   localparam logic [31:0] E_REP_LAST = 32'd1096;
   localparam logic [31:0] E_RCOUNT   = 32'd255;
`else
   localparam logic [31:0] B_REP_MASK = 32'h0;
   localparam logic [31:0] B_RCOUNT   = 32'd0;
   localparam logic [31:0] E_REP_N    = 32'd0;
   localparam logic [31:0] E_REP_LAST = 32'd0;
   localparam logic [31:0] E_RCOUNT   = 32'd0;
`endif

   int checks   = 0;
   int failures = 0;
   int multi    = 0;

   logic [31:0] pm, cm, lm, rm, hm;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic note_multi();
      if (int'(kif.press_p) + int'(kif.click_p) +
          int'(kif.long_p) + int'(kif.repeat_p) > 1)
         multi++;
   endtask

   // Bit i of pat is KEYON at edge i; bit i of each mask is output after it.
   task automatic run_pat(input logic [31:0] pat, input int len);
      pm = '0; cm = '0; lm = '0; rm = '0; hm = '0;
      for (int i = 0; i < len; i++) begin
         kif.KEYON = pat[i];
         tick();
         pm[i] = kif.press_p;
         cm[i] = kif.click_p;
         lm[i] = kif.long_p;
         rm[i] = kif.repeat_p;
         hm[i] = kif.held;
         note_multi();
      end
   endtask

   initial begin
      int rep_n;
      int rep_last;
      int long_at;

      reset_n   = 1'b0;
      kif.KEYON = 1'b0;
      #12;
      check("rst_press",  32'(kif.press_p),      32'd0);
      check("rst_click",  32'(kif.click_p),      32'd0);
      check("rst_long",   32'(kif.long_p),       32'd0);
      check("rst_repeat", 32'(kif.repeat_p),     32'd0);
      check("rst_held",   32'(kif.held),         32'd0);
      check("rst_rcount", 32'(kif.repeat_count), 32'd0);
      reset_n = 1'b1;
      tick();
      tick();

      // Short press: 3 cycles high.
      run_pat(32'h0000_0007, 8);
      check("A_press", pm, 32'h0000_0001);
      check("A_click", cm, 32'h0000_0008);
      check("A_long",  lm, 32'h0);
      check("A_held",  hm, 32'h0);

      // Long hold: 20 cycles high.
      run_pat(32'h000F_FFFF, 24);
      check("B_press",  pm, 32'h0000_0001);
      check("B_click",  cm, 32'h0);
      check("B_long",   lm, 32'h0000_0100);
      check("B_held",   hm, 32'h000F_FF00);
      check("B_repeat", rm, B_REP_MASK);
      check("B_rcount", 32'(kif.repeat_count), B_RCOUNT);
      run_pat(32'h0, 3);
      check("B_rcount_keep", 32'(kif.repeat_count), B_RCOUNT);

      // Release on the threshold edge: release wins.
      run_pat(32'h0000_00FF, 12);
      check("C_press", pm, 32'h0000_0001);
      check("C_click", cm, 32'h0000_0100);
      check("C_long",  lm, 32'h0);
      check("C_held",  hm, 32'h0);
      check("C_rcount_clr", 32'(kif.repeat_count), 32'd0);

      // Back-to-back presses with a single idle cycle between.
      run_pat(32'h0000_0037, 10);
      check("D_press", pm, 32'h0000_0011);
      check("D_click", cm, 32'h0000_0048);
      check("D_long",  lm, 32'h0);

      // 1100-cycle hold: repeat_count saturates, pulses continue.
      rep_n    = 0;
      rep_last = 0;
      long_at  = -1;
      kif.KEYON = 1'b1;
      for (int i = 0; i < 1100; i++) begin
         tick();
         note_multi();
         if (kif.repeat_p) begin
            rep_n++;
            rep_last = i;
         end
         if (kif.long_p) long_at = i;
      end
      check("E_long_at",  32'(long_at), 32'd8);
      check("E_rep_n",    32'(rep_n), E_REP_N);
      check("E_rep_last", 32'(rep_last), E_REP_LAST);
      check("E_rcount",   32'(kif.repeat_count), E_RCOUNT);
      check("E_held",     32'(kif.held), 32'd1);
      kif.KEYON = 1'b0;
      tick();
      check("E_rel_held",  32'(kif.held), 32'd0);
      check("E_rel_click", 32'(kif.click_p), 32'd0);
      tick();
      tick();

      // Partial-cycle reset during HOLD, key still down afterwards.
      kif.KEYON = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      check("F_held_pre", 32'(kif.held), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("F_rst_held",   32'(kif.held),         32'd0);
      check("F_rst_press",  32'(kif.press_p),      32'd0);
      check("F_rst_rcount", 32'(kif.repeat_count), 32'd0);
      #1;
      reset_n = 1'b1;
      tick();
      check("F_press_after", 32'(kif.press_p), 32'd1);
      check("F_held_after",  32'(kif.held),    32'd0);
      kif.KEYON = 1'b0;
      tick();
      tick();

      check("excl_pulses", 32'(multi), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
